// File: rtl/adder_test_pkg.sv
// adder_test_pkg: shared FSM states, LFSR constants and helpers for adder self-test harnesses
package adder_test_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int LFSR_W = 32;
  // right-shifting Galois form of x^32+x^22+x^2+x+1
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;
  localparam int NUM_DIRECTED = 4;
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction
endpackage

// File: rtl/adder_wrapper_selftest_if.sv
// adder_wrapper_selftest_if: operand/result bus between the self-test stage and the adder wrapper
interface adder_wrapper_selftest_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic [WIDTH-1:0] dut_sum;
  logic             dut_cout;
  modport master (output dut_a, dut_b, input dut_sum, dut_cout);
  modport slave  (input dut_a, dut_b, output dut_sum, dut_cout);
endinterface

// File: rtl/adder_test_lfsr.sv
// adder_test_lfsr: 32-bit Galois LFSR with seed load and step enable
module adder_test_lfsr
  import adder_test_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 32'hACE1_2468
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);
  always_ff @(posedge clk)
    if (!rst_n || load) q <= SEED;
    else if (step) q <= lfsr_next(q);
endmodule

// File: rtl/adder_wrapper_selftest.sv
// adder_wrapper_selftest: drives an adder wrapper with directed then random vectors and checks its results
module adder_wrapper_selftest
  import adder_test_pkg::*;
#(
  parameter int              WIDTH       = 8,
  parameter int              LATENCY     = 2,
  parameter int              NUM_VECTORS = 256,
  parameter logic [31:0]     LFSR_SEED   = 32'hACE1_2468
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [WIDTH-1:0] first_fail_a,
  output logic [WIDTH-1:0] first_fail_b,
  adder_wrapper_selftest_if.master bus
);
  localparam logic [15:0] ALT = 16'h5555;
  state_t state;
  logic [15:0] idx;
  logic [7:0] dcnt;
  logic [LFSR_W-1:0] lfsr;
  logic run_start, drv_v, mismatch;
  logic [WIDTH-1:0] vec_a, vec_b;
  logic [15:0] err_next;
  logic             dl_v   [LATENCY];
  logic [WIDTH:0]   dl_exp [LATENCY];
  logic [WIDTH-1:0] dl_a   [LATENCY];
  logic [WIDTH-1:0] dl_b   [LATENCY];
  assign run_start = start && (state == IDLE || state == DONE);
  assign vec_a = idx >= 16'(NUM_DIRECTED) ? lfsr[WIDTH-1:0] :
                 idx == 16'd3 ? ALT[WIDTH-1:0] : idx == 16'd0 ? '0 : '1;
  assign vec_b = idx >= 16'(NUM_DIRECTED) ? lfsr[16 +: WIDTH] :
                 idx == 16'd3 ? ~ALT[WIDTH-1:0] : idx == 16'd0 ? '0 :
                 idx == 16'd1 ? WIDTH'(1) : '1;
  assign mismatch = dl_v[LATENCY-1] && ({bus.dut_cout, bus.dut_sum} != dl_exp[LATENCY-1]);
  assign err_next = mismatch && err_count != 16'hFFFF ? err_count + 16'd1 : err_count;
  adder_test_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (run_start),
    .step (state == RUN && idx >= 16'(NUM_DIRECTED)),
    .q    (lfsr)
  );
  // expected sums are formed from the registered operands, so the compare lands LATENCY edges after the drive
  always_ff @(posedge clk) begin
    dl_exp[0] <= {1'b0, bus.dut_a} + {1'b0, bus.dut_b};
    dl_a[0]   <= bus.dut_a;
    dl_b[0]   <= bus.dut_b;
    for (int i = 1; i < LATENCY; i++) begin
      dl_exp[i] <= dl_exp[i-1];
      dl_a[i]   <= dl_a[i-1];
      dl_b[i]   <= dl_b[i-1];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= '0;
      first_fail_a <= '0;
      first_fail_b <= '0;
      bus.dut_a    <= '0;
      bus.dut_b    <= '0;
      drv_v        <= 1'b0;
      idx          <= '0;
      dcnt         <= '0;
      for (int i = 0; i < LATENCY; i++) dl_v[i] <= 1'b0;
    end else begin
      bus.dut_a <= state == RUN ? vec_a : '0;
      bus.dut_b <= state == RUN ? vec_b : '0;
      drv_v     <= state == RUN;
      dl_v[0]   <= drv_v;
      for (int i = 1; i < LATENCY; i++) dl_v[i] <= dl_v[i-1];
      if (mismatch) begin
        err_count <= err_next;
        if (err_count == '0) begin
          first_fail_a <= dl_a[LATENCY-1];
          first_fail_b <= dl_b[LATENCY-1];
        end
      end
      if (run_start) begin
        state        <= RUN;
        busy         <= 1'b1;
        done         <= 1'b0;
        pass         <= 1'b0;
        err_count    <= '0;
        first_fail_a <= '0;
        first_fail_b <= '0;
        idx          <= '0;
      end else if (state == RUN) begin
        idx <= idx + 16'd1;
        if (idx == 16'(NUM_VECTORS - 1)) begin
          state <= DRAIN;
          dcnt  <= '0;
        end
      end else if (state == DRAIN) begin
        dcnt <= dcnt + 8'd1;
        if (dcnt == 8'(LATENCY)) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= err_next == '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_adder_wrapper_selftest.sv
// tb_adder_wrapper_selftest: runs the self-test against good and faulty 2-cycle adder models
module tb_adder_wrapper_selftest;
  typedef struct {
    int         fault;
    bit         mid;
    bit         vec;
    bit         exp_pass;
    int         exp_err;
    logic [7:0] ffa;
    logic [7:0] ffb;
    int         done_at;
  } run_t;
  logic clk, rst_n, start;
  logic busy, done, pass, busy3, done3, pass3;
  logic [15:0] err_count, err3;
  logic [7:0] ffa, ffb, ffa3, ffb3;
  logic [8:0] r1, r2, r1_3, r2_3;
  logic [7:0] va [256];
  logic [7:0] vb [256];
  logic [15:0] q [$];
  run_t runs [5];
  int fault, n_cmp, n_fail, odd;
  adder_wrapper_selftest_if #(.WIDTH(8)) bus ();
  adder_wrapper_selftest_if #(.WIDTH(8)) bus3 ();
  adder_wrapper_selftest #(.WIDTH(8), .LATENCY(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_a(ffa), .first_fail_b(ffb), .bus(bus)
  );
  adder_wrapper_selftest #(.WIDTH(8), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .first_fail_a(ffa3), .first_fail_b(ffb3), .bus(bus3)
  );
  // behavioural wrapper: operands registered, then the sum registered
  always @(posedge clk) begin
    r1   <= {1'b0, bus.dut_a} + {1'b0, bus.dut_b};
    r2   <= r1;
    r1_3 <= {1'b0, bus3.dut_a} + {1'b0, bus3.dut_b};
    r2_3 <= r1_3;
  end
  assign bus.dut_sum   = fault == 1 ? {r2[7:1], 1'b0} : r2[7:0];
  assign bus.dut_cout  = fault == 2 ? ~r2[8] : r2[8];
  assign bus3.dut_sum  = r2_3[7:0];
  assign bus3.dut_cout = r2_3[8];
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " pass"}, pass, 0);
    chk({tag, " err"}, err_count, 0);
    chk({tag, " ff"}, {ffa, ffb}, 0);
    chk({tag, " dut_ab"}, {bus.dut_a, bus.dut_b}, 0);
    chk({tag, " l3 outs"}, {busy3, done3, pass3, err3, ffa3, ffb3}, 0);
  endtask

  task automatic run_one(input run_t r);
    int de, de3;
    logic [15:0] e_ab;
    fault = r.fault;
    q.delete();
    for (int i = 0; i < 256; i++) q.push_back({va[i], vb[i]});
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    de = 0;
    de3 = 0;
    for (int e = 1; e <= 300 && (de == 0 || de3 == 0); e++) begin
      if (r.mid && e == 50) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      if (e <= 256) begin
        e_ab = q.pop_front();
        if (r.vec) chk($sformatf("vec%0d", e - 1), {bus.dut_a, bus.dut_b}, e_ab);
      end
      if (e == 1) chk("busy after start", busy, 1);
      if (de == 0 && done) de = e;
      if (de3 == 0 && done3) de3 = e;
    end
    chk("done edge", de, r.done_at);
    chk("pass", pass, r.exp_pass);
    chk("err_count", err_count, r.exp_err);
    chk("first_fail", {ffa, ffb}, {r.ffa, r.ffb});
    chk("busy at done", busy, 0);
    chk("dut_ab at done", {bus.dut_a, bus.dut_b}, 0);
    chk("l3 done edge", de3, 260);
    chk("l3 pass", pass3, 0);
    chk("l3 first_fail", {ffa3, ffb3}, 0);
  endtask

  task automatic reset_mid_run();
    fault = 2;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (100) @(posedge clk);
    #1 chk("err before reset", err_count != 0, 1);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk_idle("midreset");
    @(posedge clk);
    #1 chk("still idle", {busy, bus.dut_a, bus.dut_b}, 0);
  endtask

  initial begin
    logic [31:0] s;
    n_cmp = 0;
    n_fail = 0;
    fault = 0;
    start = 1'b0;
    s = 32'hACE1_2468;
    odd = 0;
    for (int i = 0; i < 256; i++) begin
      case (i)
        0: begin va[i] = 8'h00; vb[i] = 8'h00; end
        1: begin va[i] = 8'hFF; vb[i] = 8'h01; end
        2: begin va[i] = 8'hFF; vb[i] = 8'hFF; end
        3: begin va[i] = 8'h55; vb[i] = 8'hAA; end
        default: begin
          va[i] = s[7:0];
          vb[i] = s[23:16];
          s = {s[0], s[31:1]} ^ (s[0] ? 32'h0020_0003 : 32'h0);
        end
      endcase
      odd += int'(va[i][0] ^ vb[i][0]);
    end
    runs[0] = '{0, 1'b0, 1'b1, 1'b1, 0,   8'h00, 8'h00, 259};
    runs[1] = '{1, 1'b0, 1'b0, 1'b0, odd, 8'h55, 8'hAA, 259};
    runs[2] = '{2, 1'b0, 1'b0, 1'b0, 256, 8'h00, 8'h00, 259};
    runs[3] = '{0, 1'b1, 1'b0, 1'b1, 0,   8'h00, 8'h00, 259};
    runs[4] = '{0, 1'b0, 1'b1, 1'b1, 0,   8'h00, 8'h00, 259};
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_idle("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) reset_mid_run();
      run_one(runs[i]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
